// File: rtl/fmul_pipe.sv
// fmul_pipe: three-stage floating-point multiplier with round-to-nearest-even,
// DAZ/FTZ, special operands and {invalid, overflow, underflow, inexact} flags.
module fmul_pipe #(
  parameter  int EXP_W  = 8,
  parameter  int FRAC_W = 23,
  localparam int W      = 1 + EXP_W + FRAC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EW   = EXP_W + 2;
  localparam int MW   = FRAC_W + 1;
  localparam int PW   = 2 * FRAC_W + 2;

  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic signed [EW-1:0] E_ZERO = '0;
  localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);

  localparam logic [W-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

  typedef struct packed {
    logic          sign;
    logic [EW-1:0] exp;
    logic [MW-1:0] ma;
    logic [MW-1:0] mb;
    logic          spec;
    logic [W-1:0]  spec_res;
    logic [3:0]    spec_flags;
  } s1_t;

  typedef struct packed {
    logic          sign;
    logic [EW-1:0] exp;
    logic [PW-1:0] prod;
    logic          spec;
    logic [W-1:0]  spec_res;
    logic [3:0]    spec_flags;
  } s2_t;

  logic         adv;
  logic         v1, v2;
  s1_t          s1_d, s1_q;
  s2_t          s2_d, s2_q;
  logic [W-1:0] res_d;
  logic [3:0]   flg_d;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv & !rst;

  logic              sa, sb;
  logic [EXP_W-1:0]  ea, eb;
  logic [FRAC_W-1:0] fa, fb;
  logic              a_zero, a_inf, a_nan;
  logic              b_zero, b_inf, b_nan;
  logic              zero_inf, snan;
  logic              is_nan, is_inf, is_zero;

  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;

  // Subnormal operands fall into the zero class.
  assign a_zero = ~|ea;
  assign a_inf  = (&ea) & (~|fa);
  assign a_nan  = (&ea) & (|fa);
  assign b_zero = ~|eb;
  assign b_inf  = (&eb) & (~|fb);
  assign b_nan  = (&eb) & (|fb);

  assign zero_inf = (a_zero & b_inf) | (a_inf & b_zero);
  assign snan     = (a_nan & ~fa[FRAC_W-1])
                  | (b_nan & ~fb[FRAC_W-1]);
  assign is_nan   = a_nan | b_nan | zero_inf;
  assign is_inf   = ~is_nan & (a_inf | b_inf);
  assign is_zero  = ~is_nan & ~is_inf & (a_zero | b_zero);

  always_comb begin
    s1_d      = '0;
    s1_d.sign = sa ^ sb;
    s1_d.exp  = EW'(ea) + EW'(eb) - EW'(BIAS);
    s1_d.ma   = {|ea, fa};
    s1_d.mb   = {|eb, fb};
    s1_d.spec = is_nan | is_inf | is_zero;
    unique case (1'b1)
      is_nan: begin
        s1_d.spec_res   = QNAN;
        s1_d.spec_flags = {zero_inf | snan, 3'b000};
      end
      is_inf:
        s1_d.spec_res = {sa ^ sb, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      is_zero:
        s1_d.spec_res = {sa ^ sb, {(W-1){1'b0}}};
      default:
        s1_d.spec_res = '0;
    endcase
  end

  always_comb begin
    s2_d            = '0;
    s2_d.sign       = s1_q.sign;
    s2_d.exp        = s1_q.exp;
    s2_d.prod       = PW'(s1_q.ma) * PW'(s1_q.mb);
    s2_d.spec       = s1_q.spec;
    s2_d.spec_res   = s1_q.spec_res;
    s2_d.spec_flags = s1_q.spec_flags;
  end

  logic signed [EW-1:0] e_n, e_r;
  logic [MW-1:0]        mant;
  logic [MW:0]          rnd;
  logic [FRAC_W-1:0]    frac;
  logic                 guard, sticky, inc, inexact;
  logic                 ovf, unf;
  logic                 unused_hidden;

  always_comb begin
    e_n    = s2_q.exp;
    mant   = s2_q.prod[PW-2 -: MW];
    guard  = s2_q.prod[FRAC_W-1];
    sticky = |s2_q.prod[FRAC_W-2:0];
    if (s2_q.prod[PW-1]) begin
      e_n    = e_n + E_ONE;
      mant   = s2_q.prod[PW-1 -: MW];
      guard  = s2_q.prod[FRAC_W];
      sticky = |s2_q.prod[FRAC_W-1:0];
    end
    inc     = guard & (sticky | mant[0]);
    rnd     = {1'b0, mant} + (MW+1)'(inc);
    inexact = guard | sticky;
    e_r     = e_n;
    frac    = rnd[FRAC_W-1:0];
    if (rnd[MW]) begin
      e_r  = e_n + E_ONE;
      frac = '0;
    end
    ovf = e_r >= E_MAX;
    unf = e_r <= E_ZERO;
  end

  // A rounded significand always keeps its leading one.
  assign unused_hidden = rnd[FRAC_W];

  always_comb begin
    res_d = '0;
    flg_d = '0;
    unique case (1'b1)
      s2_q.spec: begin
        res_d = s2_q.spec_res;
        flg_d = s2_q.spec_flags;
      end
      !s2_q.spec && ovf: begin
        res_d = {s2_q.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        flg_d = 4'b0101;
      end
      !s2_q.spec && !ovf && unf: begin
        res_d = {s2_q.sign, {(W-1){1'b0}}};
        flg_d = 4'b0011;
      end
      default: begin
        res_d = {s2_q.sign, e_r[EXP_W-1:0], frac};
        flg_d = {3'b000, inexact};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (adv) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      result    <= res_d;
      flags     <= flg_d;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

endmodule

// File: tb/tb_fmul_pipe.sv
// tb_fmul_pipe: directed and randomized checks of fmul_pipe against an
// integer-arithmetic reference model, with backpressure and reset cases.
module tb_fmul_pipe;
  localparam int W  = 32;
  localparam int TR = 4096;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [35:0] exp_q[$];
  int          acc_q[$];
  logic [35:0] got_q[$];
  int          got_cyc_q[$];

  logic        ov_tr[TR];
  logic        ir_tr[TR];
  logic [35:0] ob_tr[TR];

  always #5 clk = ~clk;

  fmul_pipe dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .flags(flags)
  );

  // Reference: exact integer product, rounded by remainder comparison.
  function automatic logic [35:0] model(input logic [31:0] x,
                                        input logic [31:0] y);
    int     ex, ey, e, s;
    longint fx, fy, p, q, rem, half;
    bit     sgn, xz, yz, xi, yi, xn, yn, inv, inx;
    ex  = int'(x[30:23]);
    ey  = int'(y[30:23]);
    fx  = longint'(x[22:0]);
    fy  = longint'(y[22:0]);
    sgn = x[31] ^ y[31];
    xz  = (ex == 0);
    yz  = (ey == 0);
    xi  = (ex == 255) && (fx == 0);
    yi  = (ey == 255) && (fy == 0);
    xn  = (ex == 255) && (fx != 0);
    yn  = (ey == 255) && (fy != 0);
    if (xn || yn || (xz && yi) || (xi && yz)) begin
      inv = (xz && yi) || (xi && yz)
         || (xn && fx < 4194304) || (yn && fy < 4194304);
      return {32'h7FC00000, inv, 3'b000};
    end
    if (xi || yi) return {sgn, 8'hFF, 23'd0, 4'b0000};
    if (xz || yz) return {sgn, 31'd0, 4'b0000};
    p = (fx + 8388608) * (fy + 8388608);
    e = ex + ey - 127;
    if (p >= (longint'(1) << 47)) begin
      s = 24;
      e = e + 1;
    end else begin
      s = 23;
    end
    q    = p >> s;
    rem  = p - (q << s);
    half = longint'(1) << (s - 1);
    if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
    if (q == (longint'(1) << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    inx = (rem != 0);
    if (e >= 255) return {sgn, 8'hFF, 23'd0, 4'b0101};
    if (e <= 0) return {sgn, 31'd0, 4'b0011};
    return {sgn, 8'(e), 23'(q), 3'b000, inx};
  endfunction

  function automatic logic [31:0] rand_op();
    logic       s;
    logic [7:0] e;
    logic [22:0] f;
    s = 1'($urandom);
    f = 23'($urandom);
    case ($urandom_range(0, 11))
      0: begin e = 8'h00; f = '0; end
      1: begin e = 8'hFF; f = '0; end
      2: begin e = 8'hFF; f[22] = 1'b1; end
      3: begin e = 8'hFF; f[22] = 1'b0; f[0] = 1'b1; end
      4: e = 8'h00;
      5: e = 8'(240 + $urandom_range(0, 14));
      6: e = 8'($urandom_range(1, 20));
      7: begin e = 8'($urandom_range(100, 154)); f = '1; end
      default: e = 8'($urandom_range(64, 190));
    endcase
    return {s, e, f};
  endfunction

  task automatic clear_sb();
    exp_q.delete();
    acc_q.delete();
    got_q.delete();
    got_cyc_q.delete();
  endtask

  // One clock: drive, record handshakes and outputs, advance to next negedge.
  task automatic cycle(input logic iv, input logic [31:0] xa,
                       input logic [31:0] xb, input logic ordy,
                       input logic r);
    rst       = r;
    in_valid  = iv;
    a         = xa;
    b         = xb;
    out_ready = ordy;
    #1;
    if (cyc < TR) begin
      ov_tr[cyc] = out_valid;
      ir_tr[cyc] = in_ready;
      ob_tr[cyc] = {result, flags};
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(model(xa, xb));
      acc_q.push_back(cyc);
    end
    if (out_valid && out_ready) begin
      got_q.push_back({result, flags});
      got_cyc_q.push_back(cyc);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < budget) begin
      cycle(1'b0, '0, '0, 1'b1, 1'b0);
      n++;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, '1, '1, 1'b1, 1'b1);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    checks++;
    if (ov_tr[cyc-1] !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=0", ov_tr[cyc-1]);
    end
    checks++;
    if (ob_tr[cyc-1] !== 36'd0) begin
      failures++;
      $display("FAIL reset_result got=%h exp=0", ob_tr[cyc-1]);
    end
    checks++;
    if (ir_tr[cyc-1] !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", ir_tr[cyc-1]);
    end
    checks++;
    if (got_q.size() != 0) begin
      failures++;
      $display("FAIL reset_no_output got=%0d exp=0", got_q.size());
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta[9] = '{32'h3FC00000, 32'h3F800001, 32'h3F800800,
                           32'h7F000000, 32'h00800000, 32'h00000000,
                           32'hFF800000, 32'h7FA00000, 32'hBF800000};
    logic [31:0] tb[9] = '{32'h40000000, 32'h3F800001, 32'h3F800800,
                           32'h7F000000, 32'h3F000000, 32'h7F800000,
                           32'h40000000, 32'h3F800000, 32'h00000000};
    logic [31:0] tr[9] = '{32'h40400000, 32'h3F800002, 32'h3F801000,
                           32'h7F800000, 32'h00000000, 32'h7FC00000,
                           32'hFF800000, 32'h7FC00000, 32'h80000000};
    logic [3:0]  tf[9] = '{4'b0000, 4'b0001, 4'b0001,
                           4'b0101, 4'b0011, 4'b1000,
                           4'b0000, 4'b1000, 4'b0000};
    for (int i = 0; i < 9; i++) begin
      clear_sb();
      cycle(1'b1, ta[i], tb[i], 1'b1, 1'b0);
      drain(10);
      checks++;
      if (got_q.size() != 1) begin
        failures++;
        $display("FAIL directed%0d_count got=%0d exp=1", i, got_q.size());
      end else begin
        checks++;
        if (got_q[0][35:4] !== tr[i]) begin
          failures++;
          $display("FAIL directed%0d_result got=%h exp=%h",
                   i, got_q[0][35:4], tr[i]);
        end
        checks++;
        if (got_q[0][3:0] !== tf[i]) begin
          failures++;
          $display("FAIL directed%0d_flags got=%b exp=%b",
                   i, got_q[0][3:0], tf[i]);
        end
        checks++;
        if (got_cyc_q[0] - acc_q[0] != 3) begin
          failures++;
          $display("FAIL directed%0d_latency got=%0d exp=3",
                   i, got_cyc_q[0] - acc_q[0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] oa[8], ob[8];
    int c0, k;
    for (int i = 0; i < 8; i++) begin
      oa[i] = rand_op();
      ob[i] = rand_op();
    end
    clear_sb();
    c0 = cyc;
    for (int t = 0; t < 30; t++) begin
      k = (acc_q.size() < 8) ? acc_q.size() : 7;
      cycle(acc_q.size() < 8, oa[k], ob[k], !(t >= 4 && t <= 7), 1'b0);
    end
    for (int t = 4; t <= 7; t++) begin
      checks++;
      if (ov_tr[c0+t] !== 1'b1 || ir_tr[c0+t] !== 1'b0) begin
        failures++;
        $display("FAIL b2b_stall t=%0d got_valid=%b got_in_ready=%b exp=1/0",
                 t, ov_tr[c0+t], ir_tr[c0+t]);
      end
      checks++;
      if (ob_tr[c0+t+1] !== ob_tr[c0+t] || ov_tr[c0+t+1] !== 1'b1) begin
        failures++;
        $display("FAIL b2b_hold t=%0d got=%h exp=%h",
                 t, ob_tr[c0+t+1], ob_tr[c0+t]);
      end
    end
    checks++;
    if (got_q.size() != 8) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=8", got_q.size());
    end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== model(oa[i], ob[i])) begin
        failures++;
        $display("FAIL b2b_order%0d got=%h exp=%h",
                 i, got_q[i], model(oa[i], ob[i]));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] ca, cb;
    int n_acc;
    clear_sb();
    ca = rand_op();
    cb = rand_op();
    for (int t = 0; t < 400; t++) begin
      n_acc = acc_q.size();
      cycle($urandom_range(0, 9) < 7, ca, cb, $urandom_range(0, 3) != 0, 1'b0);
      if (acc_q.size() != n_acc) begin
        ca = rand_op();
        cb = rand_op();
      end
    end
    drain(20);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL random_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL random%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] xa, xb;
    logic [35:0] want;
    clear_sb();
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_op(), rand_op(), 1'b1, 1'b0);
    cycle(1'b1, rand_op(), rand_op(), 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    checks++;
    if (ov_tr[cyc-1] !== 1'b0 || ob_tr[cyc-1] !== 36'd0) begin
      failures++;
      $display("FAIL midreset_clear got_valid=%b got=%h exp=0/0",
               ov_tr[cyc-1], ob_tr[cyc-1]);
    end
    checks++;
    if (ir_tr[cyc-1] !== 1'b1) begin
      failures++;
      $display("FAIL midreset_in_ready got=%b exp=1", ir_tr[cyc-1]);
    end
    clear_sb();
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    checks++;
    if (got_q.size() != 0) begin
      failures++;
      $display("FAIL midreset_stale got=%0d exp=0", got_q.size());
    end
    xa = 32'h40490FDB;
    xb = 32'hC0000000;
    want = model(xa, xb);
    clear_sb();
    cycle(1'b1, xa, xb, 1'b1, 1'b0);
    drain(10);
    checks++;
    if (got_q.size() != 1) begin
      failures++;
      $display("FAIL midreset_count got=%0d exp=1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== want) begin
        failures++;
        $display("FAIL midreset_result got=%h exp=%h", got_q[0], want);
      end
      checks++;
      if (got_cyc_q[0] - acc_q[0] != 3) begin
        failures++;
        $display("FAIL midreset_latency got=%0d exp=3",
                 got_cyc_q[0] - acc_q[0]);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
